// File: rtl/bru_pkg.sv
// Shared opcodes, funct3 encodings and BHT counter type for the branch resolve unit.
package bru_pkg;

  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  typedef enum logic [2:0] {
    F3_BEQ  = 3'b000,
    F3_BNE  = 3'b001,
    F3_BLT  = 3'b100,
    F3_BGE  = 3'b101,
    F3_BLTU = 3'b110,
    F3_BGEU = 3'b111
  } br_funct3_e;

  typedef logic [1:0] bht_ctr_t;

  localparam bht_ctr_t BHT_RESET = 2'b01;

  // Saturating 2-bit step towards taken or not-taken.
  function automatic bht_ctr_t bht_next(input bht_ctr_t ctr, input logic taken);
    bht_ctr_t nxt;
    if (taken) begin
      nxt = (ctr == 2'b11) ? ctr : ctr + 2'b01;
    end else begin
      nxt = (ctr == 2'b00) ? ctr : ctr - 2'b01;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/bht_sat_table.sv
// Array of 2-bit saturating counters with one combinational read port and one update port.
module bht_sat_table
  import bru_pkg::*;
#(
  parameter int  ENTRIES = 64,
  localparam int IDX_W   = $clog2(ENTRIES)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IDX_W-1:0] rd_idx,
  output bht_ctr_t         rd_ctr,
  input  logic             upd_en,
  input  logic [IDX_W-1:0] upd_idx,
  input  logic             upd_taken
);

  bht_ctr_t ctr_r [ENTRIES];

  // Read sees the stored value only, so an update in the same cycle shows up one edge later.
  assign rd_ctr = ctr_r[rd_idx];

  // Counter storage: async reset to weakly not-taken, saturating update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        ctr_r[i] <= BHT_RESET;
      end
    end else if (upd_en) begin
      ctr_r[upd_idx] <= bht_next(ctr_r[upd_idx], upd_taken);
    end
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// EX-stage branch/jump resolution with a registered result, mispredict flag and 2-bit BHT.
// Optional macro BRU_PERF_CNT_EN adds resolved-branch and mispredict counters.
module branch_resolve_unit
  import bru_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int BHT_ENTRIES = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ex_valid_i,
  input  logic            stall_i,
  input  logic            flush_i,
  input  logic [6:0]      opcode_i,
  input  logic [2:0]      funct3_i,
  input  logic [XLEN-1:0] src_a_i,
  input  logic [XLEN-1:0] src_b_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic            pred_taken_i,
  input  logic [XLEN-1:0] fetch_pc_i,
  output logic            fetch_pred_o,
  output logic            res_valid_o,
  output logic            br_taken_o,
  output logic            mispredict_o
`ifdef BRU_PERF_CNT_EN
  ,
  output logic [31:0]     br_count_o,
  output logic [31:0]     mispredict_count_o
`endif
);

  localparam int BHT_IDX_W = $clog2(BHT_ENTRIES);

  logic [XLEN:0]          diff_s;
  logic                   eq_s;
  logic                   ltu_s;
  logic                   ovf_s;
  logic                   lt_s;
  logic                   is_branch_s;
  logic                   is_jump_s;
  logic                   taken_s;
  logic                   resolve_s;
  logic                   bht_upd_s;
  logic [BHT_IDX_W-1:0]   fetch_idx_s;
  logic [BHT_IDX_W-1:0]   ex_idx_s;
  bht_ctr_t               fetch_ctr_s;
  logic                   res_valid_r;
  logic                   br_taken_r;
  logic                   mispredict_r;
  logic                   unused_s;

  assign diff_s = {1'b0, src_a_i} - {1'b0, src_b_i};
  assign eq_s   = (diff_s[XLEN-1:0] == {XLEN{1'b0}});
  assign ltu_s  = diff_s[XLEN];
  // a-b overflows when operand signs differ and the result sign no longer matches a.
  assign ovf_s  = (src_a_i[XLEN-1] ^ src_b_i[XLEN-1]) & (diff_s[XLEN-1] ^ src_a_i[XLEN-1]);
  assign lt_s   = diff_s[XLEN-1] ^ ovf_s;

  // Decode the instruction class and pick the resolved direction.
  always_comb begin
    is_branch_s = 1'b0;
    is_jump_s   = 1'b0;
    taken_s     = 1'b0;
    if ((opcode_i == OPC_JAL) || (opcode_i == OPC_JALR)) begin
      is_jump_s = 1'b1;
      taken_s   = 1'b1;
    end else if (opcode_i == OPC_BRANCH) begin
      is_branch_s = 1'b1;
      case (funct3_i)
        F3_BEQ:  taken_s = eq_s;
        F3_BNE:  taken_s = ~eq_s;
        F3_BLT:  taken_s = lt_s;
        F3_BGE:  taken_s = ~lt_s;
        F3_BLTU: taken_s = ltu_s;
        F3_BGEU: taken_s = ~ltu_s;
        default: is_branch_s = 1'b0;
      endcase
    end else begin
      is_branch_s = 1'b0;
    end
  end

  assign resolve_s   = ex_valid_i & ~flush_i & (is_branch_s | is_jump_s);
  assign bht_upd_s   = ~stall_i & resolve_s & is_branch_s;
  assign fetch_idx_s = fetch_pc_i[BHT_IDX_W+1:2];
  assign ex_idx_s    = pc_i[BHT_IDX_W+1:2];

  bht_sat_table #(
    .ENTRIES (BHT_ENTRIES)
  ) u_bht (
    .clk       (clk),
    .rst_n     (rst_n),
    .rd_idx    (fetch_idx_s),
    .rd_ctr    (fetch_ctr_s),
    .upd_en    (bht_upd_s),
    .upd_idx   (ex_idx_s),
    .upd_taken (taken_s)
  );

  assign fetch_pred_o = fetch_ctr_s[1];

  // Result registers; stall freezes them, which also masks any flush in that cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_valid_r  <= 1'b0;
      br_taken_r   <= 1'b0;
      mispredict_r <= 1'b0;
    end else if (!stall_i) begin
      res_valid_r  <= resolve_s;
      br_taken_r   <= resolve_s & taken_s;
      mispredict_r <= resolve_s & (taken_s ^ pred_taken_i);
    end
  end

  assign res_valid_o  = res_valid_r;
  assign br_taken_o   = br_taken_r;
  assign mispredict_o = mispredict_r;

`ifdef BRU_PERF_CNT_EN
  logic [31:0] br_count_r;
  logic [31:0] mispredict_count_r;

  // Event counters, wrapping naturally at 32 bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      br_count_r         <= 32'd0;
      mispredict_count_r <= 32'd0;
    end else if (!stall_i && resolve_s) begin
      br_count_r <= br_count_r + 32'd1;
      if (taken_s ^ pred_taken_i) begin
        mispredict_count_r <= mispredict_count_r + 32'd1;
      end
    end
  end

  assign br_count_o         = br_count_r;
  assign mispredict_count_o = mispredict_count_r;
`endif

  // Index bits outside the BHT window and the counter LSB are intentionally ignored.
  assign unused_s = ^{pc_i[XLEN-1:BHT_IDX_W+2], pc_i[1:0],
                      fetch_pc_i[XLEN-1:BHT_IDX_W+2], fetch_pc_i[1:0], fetch_ctr_s[0]};

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed plus randomized bench for branch_resolve_unit against a behavioural reference model.
module tb_branch_resolve_unit;
  import bru_pkg::*;

  localparam int XLEN    = 32;
  localparam int ENTRIES = 64;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ex_valid;
  logic        stall;
  logic        flush;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic [31:0] pc;
  logic        pred_taken;
  logic [31:0] fetch_pc;
  logic        fetch_pred;
  logic        res_valid;
  logic        br_taken;
  logic        mispredict;
`ifdef BRU_PERF_CNT_EN
  logic [31:0] br_count;
  logic [31:0] mis_count;
`endif

  branch_resolve_unit #(
    .XLEN        (XLEN),
    .BHT_ENTRIES (ENTRIES)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ex_valid_i   (ex_valid),
    .stall_i      (stall),
    .flush_i      (flush),
    .opcode_i     (opcode),
    .funct3_i     (funct3),
    .src_a_i      (src_a),
    .src_b_i      (src_b),
    .pc_i         (pc),
    .pred_taken_i (pred_taken),
    .fetch_pc_i   (fetch_pc),
    .fetch_pred_o (fetch_pred),
    .res_valid_o  (res_valid),
    .br_taken_o   (br_taken),
    .mispredict_o (mispredict)
`ifdef BRU_PERF_CNT_EN
    ,
    .br_count_o         (br_count),
    .mispredict_count_o (mis_count)
`endif
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          m_bht [ENTRIES];
  bit          m_valid;
  bit          m_taken;
  bit          m_mis;
  int unsigned m_brc;
  int unsigned m_misc;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int idx_of(input logic [31:0] a);
    return int'((a >> 2) % ENTRIES);
  endfunction

  function automatic bit ref_taken(input logic [6:0] opc, input logic [2:0] f3,
                                   input logic [31:0] a, input logic [31:0] b);
    if (opc == OPC_JAL || opc == OPC_JALR) return 1'b1;
    if (opc != OPC_BRANCH) return 1'b0;
    case (f3)
      3'b000:  return a == b;
      3'b001:  return a != b;
      3'b100:  return $signed(a) < $signed(b);
      3'b101:  return $signed(a) >= $signed(b);
      3'b110:  return a < b;
      3'b111:  return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  function automatic bit ref_is_branch(input logic [6:0] opc, input logic [2:0] f3);
    return (opc == OPC_BRANCH) && (f3 != 3'b010) && (f3 != 3'b011);
  endfunction

  task automatic model_reset();
    foreach (m_bht[i]) m_bht[i] = 1;
    m_valid = 1'b0;
    m_taken = 1'b0;
    m_mis   = 1'b0;
    m_brc   = 0;
    m_misc  = 0;
  endtask

  task automatic drive(input logic v, input logic st, input logic fl, input logic [6:0] opc,
                       input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] p, input logic pr, input logic [31:0] fp);
    ex_valid   = v;
    stall      = st;
    flush      = fl;
    opcode     = opc;
    funct3     = f3;
    src_a      = a;
    src_b      = b;
    pc         = p;
    pred_taken = pr;
    fetch_pc   = fp;
  endtask

  // One clock with the currently driven inputs; checks fetch prediction before and all outputs after.
  task automatic tick(input string tag);
    bit is_br;
    bit res;
    bit tk;
    int i;
    #1;
    check({tag, "/fetch_pre"}, fetch_pred, m_bht[idx_of(fetch_pc)] >= 2);
    is_br = ref_is_branch(opcode, funct3);
    res   = ex_valid && !flush && (is_br || opcode == OPC_JAL || opcode == OPC_JALR);
    tk    = ref_taken(opcode, funct3, src_a, src_b);
    if (!stall) begin
      m_valid = res;
      m_taken = res && tk;
      m_mis   = res && (tk != pred_taken);
      if (res && is_br) begin
        i = idx_of(pc);
        m_bht[i] = tk ? ((m_bht[i] == 3) ? 3 : m_bht[i] + 1) : ((m_bht[i] == 0) ? 0 : m_bht[i] - 1);
      end
      if (res) begin
        m_brc++;
        if (tk != pred_taken) m_misc++;
      end
    end
    @(posedge clk);
    @(negedge clk);
    #1;
    check({tag, "/res_valid"}, res_valid, m_valid);
    check({tag, "/br_taken"}, br_taken, m_taken);
    check({tag, "/mispredict"}, mispredict, m_mis);
    check({tag, "/fetch_post"}, fetch_pred, m_bht[idx_of(fetch_pc)] >= 2);
`ifdef BRU_PERF_CNT_EN
    check({tag, "/br_count"}, br_count, m_brc);
    check({tag, "/mis_count"}, mis_count, m_misc);
`endif
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "/res_valid"}, res_valid, 1'b0);
    check({tag, "/br_taken"}, br_taken, 1'b0);
    check({tag, "/mispredict"}, mispredict, 1'b0);
    for (int i = 0; i < ENTRIES; i++) begin
      fetch_pc = 32'(i * 4);
      #1;
      check({tag, "/fetch_pred"}, fetch_pred, 1'b0);
    end
  endtask

  logic [6:0]  r_opc;
  logic [31:0] r_a;
  logic [31:0] r_b;

  initial begin
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 7'd0, 3'd0, 32'd0, 32'd0, 32'd0, 1'b0, 32'd0);
    model_reset();
    repeat (2) @(negedge clk);
    check_reset_state("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Signed vs unsigned compare on the same operands.
    drive(1'b1, 1'b0, 1'b0, OPC_BRANCH, 3'b100, 32'hFFFF_FFFF, 32'h1, 32'h208, 1'b0, 32'h208);
    tick("blt");
    check("blt_taken", br_taken, 1'b1);
    check("blt_mis", mispredict, 1'b1);
    drive(1'b1, 1'b0, 1'b0, OPC_BRANCH, 3'b110, 32'hFFFF_FFFF, 32'h1, 32'h208, 1'b0, 32'h208);
    tick("bltu");
    check("bltu_valid", res_valid, 1'b1);
    check("bltu_taken", br_taken, 1'b0);
    check("bltu_mis", mispredict, 1'b0);

    // Counter saturation at idx 0, then two not-taken steps back to weakly not-taken.
    drive(1'b1, 1'b0, 1'b0, OPC_BRANCH, 3'b000, 32'd5, 32'd5, 32'h100, 1'b1, 32'h100);
    for (int k = 0; k < 4; k++) begin
      tick("beq_sat");
      check("beq_sat_pred", fetch_pred, 1'b1);
    end
    drive(1'b1, 1'b0, 1'b0, OPC_BRANCH, 3'b000, 32'd5, 32'd6, 32'h100, 1'b1, 32'h100);
    tick("beq_nt1");
    check("beq_nt1_pred", fetch_pred, 1'b1);
    tick("beq_nt2");
    check("beq_nt2_pred", fetch_pred, 1'b0);

    // Stall holds outputs and ignores flush; unstalled flush suppresses the BHT update.
    drive(1'b1, 1'b0, 1'b0, OPC_BRANCH, 3'b000, 32'd9, 32'd9, 32'h10C, 1'b0, 32'h10C);
    tick("pre_stall");
    drive(1'b1, 1'b1, 1'b0, OPC_JAL, 3'b000, 32'd0, 32'd0, 32'h10C, 1'b1, 32'h10C);
    repeat (3) tick("stall");
    drive(1'b1, 1'b1, 1'b1, OPC_BRANCH, 3'b000, 32'd1, 32'd2, 32'h10C, 1'b0, 32'h10C);
    tick("stall_flush");
    check("stall_hold_mis", mispredict, 1'b1);
    drive(1'b1, 1'b0, 1'b1, OPC_BRANCH, 3'b000, 32'd1, 32'd2, 32'h10C, 1'b0, 32'h10C);
    tick("flush");
    check("flush_valid", res_valid, 1'b0);
    check("flush_bht", fetch_pred, 1'b1);

    // Asynchronous reset in the middle of a stall.
    drive(1'b1, 1'b0, 1'b0, OPC_JALR, 3'b000, 32'd0, 32'd0, 32'h110, 1'b0, 32'h10C);
    tick("jalr");
    drive(1'b1, 1'b1, 1'b0, OPC_JAL, 3'b000, 32'd0, 32'd0, 32'h110, 1'b0, 32'h10C);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_reset_state("mid_stall_reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Same-index read and update: old value this cycle, new value next.
    drive(1'b1, 1'b0, 1'b0, OPC_BRANCH, 3'b000, 32'd7, 32'd7, 32'h104, 1'b0, 32'h104);
    tick("same_idx");
    check("same_idx_post", fetch_pred, 1'b1);

    // Randomized traffic.
    for (int k = 0; k < 400; k++) begin
      case ($urandom_range(0, 5))
        0, 1, 2: r_opc = OPC_BRANCH;
        3:       r_opc = OPC_JAL;
        4:       r_opc = OPC_JALR;
        default: r_opc = 7'b0110011;
      endcase
      r_a = $urandom;
      case ($urandom_range(0, 3))
        0:       r_b = r_a;
        1:       r_b = r_a ^ 32'h8000_0000;
        default: r_b = $urandom;
      endcase
      drive($urandom_range(0, 7) != 0, $urandom_range(0, 7) == 0, $urandom_range(0, 9) == 0,
            r_opc, 3'($urandom_range(0, 7)), r_a, r_b,
            32'h1000 + 32'($urandom_range(0, 7)) * 32'd4, 1'($urandom_range(0, 1)),
            32'h1000 + 32'($urandom_range(0, 7)) * 32'd4);
      tick("rand");
    end

`ifdef BRU_PERF_CNT_EN
    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 10; k++) begin
      drive(1'b1, 1'b0, 1'b0, OPC_BRANCH, 3'b000, 32'd3, 32'd3, 32'h200, 1'(k >= 3), 32'h0);
      tick("perf");
    end
    check("perf_br10", br_count, 32'd10);
    check("perf_mis3", mis_count, 32'd3);
    force dut.br_count_r = 32'hFFFF_FFFF;
    force dut.mispredict_count_r = 32'hFFFF_FFFF;
    #1;
    release dut.br_count_r;
    release dut.mispredict_count_r;
    m_brc  = 32'hFFFF_FFFF;
    m_misc = 32'hFFFF_FFFF;
    drive(1'b1, 1'b0, 1'b0, OPC_BRANCH, 3'b001, 32'd3, 32'd3, 32'h200, 1'b1, 32'h0);
    tick("perf_wrap");
    check("perf_wrap_br", br_count, 32'd0);
    check("perf_wrap_mis", mis_count, 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
- Parametrised successor to the EX-stage branch-condition logic.
- Resolves B-type, JAL and JALR instructions for XLEN-wide operands and registers the result one cycle later.
- Flags a mispredict against the fetch-time prediction.
- Owns a BHT of 2-bit saturating counters, read combinationally by fetch and trained by resolved conditional branches.

Parameters:
- XLEN, 32, operand width in bits.
- BHT_ENTRIES, 64, number of 2-bit counters; power of two, at least 2.
- BHT_IDX_W, $clog2(BHT_ENTRIES), index width (derived, not overridden).

Ports:
- clk  in  1  core clock.
- rst_n  in  1  asynchronous active-low reset.
- ex_valid_i  in  1  EX holds a valid instruction.
- stall_i  in  1  pipeline stall; hold all state.
- flush_i  in  1  kill the EX instruction this cycle.
- opcode_i  in  7  EX opcode.
- funct3_i  in  3  EX funct3.
- src_a_i  in  XLEN  forwarded rs1.
- src_b_i  in  XLEN  forwarded rs2.
- pc_i  in  XLEN  EX pc.
- pred_taken_i  in  1  prediction that travelled down with the instruction.
- fetch_pc_i  in  XLEN  fetch-stage pc.
- fetch_pred_o  out  1  BHT prediction for fetch_pc_i (combinational).
- res_valid_o  out  1  registered: a branch or jump resolved.
- br_taken_o  out  1  registered resolved direction.
- mispredict_o  out  1  registered: br_taken_o differs from the carried prediction.

Behaviour:
- Reset (async, rst_n=0): res_valid_o=0, br_taken_o=0, mispredict_o=0; every BHT counter = 2'b01 (weakly not-taken).
- Compare is combinational in EX:
  - diff = {1'b0,a} - {1'b0,b}, XLEN+1 bits.
  - eq = (diff[XLEN-1:0]==0).
  - ltu = diff[XLEN].
  - lt = diff[XLEN-1] ^ signed overflow.
- Direction by funct3: BEQ 000=eq, BNE 001=~eq, BLT 100=lt, BGE 101=~lt, BLTU 110=ltu, BGEU 111=~ltu. funct3 010/011 gives not-taken and the instruction is not treated as a branch (no res_valid).
- JAL 1101111 and JALR 1100111: taken=1, no BHT update.
- resolve = ex_valid_i & ~flush_i & (B-type with legal funct3, or JAL, or JALR).
- Latency: 1 cycle. Values presented in cycle N appear on the outputs at edge N+1.
- stall_i=1 takes priority over everything:
  - output registers and BHT hold;
  - flush_i is ignored while stall_i=1.
- Unstalled, non-resolving cycle: res_valid_o=0, mispredict_o=0; br_taken_o=0.
- Unstalled resolving cycle: res_valid_o=1, br_taken_o=taken, mispredict_o = taken ^ pred_taken_i.
- BHT index = pc[BHT_IDX_W+1:2] for both fetch_pc_i and pc_i.
- BHT update on a resolving B-type, at the same edge as the output capture:
  - taken: counter+1, saturating at 11;
  - not-taken: counter-1, saturating at 00.
- fetch_pred_o = counter[1] of the fetch index.
- Same-cycle read/write of one index: fetch_pred_o shows the pre-update value (no bypass).
- A mispredict is reported only. Redirect and flush generation belong to the hazard unit.
- rst_n asserted mid-stall still clears everything immediately.

Optional Feature:
- Macro: BRU_PERF_CNT_EN.
- When defined, adds outputs br_count_o[31:0] and mispredict_count_o[31:0].
  - Both reset to 0 and increment by 1 on each unstalled resolving cycle, the second only when it mispredicts.
  - Both wrap from 0xFFFFFFFF to 0.
- When undefined, these ports and registers do not exist and behaviour is otherwise identical.

Decomposition:
- Package bru_pkg holds:
  - opcode constants OPC_BRANCH, OPC_JAL, OPC_JALR;
  - a funct3 enum br_funct3_e (BEQ..BGEU);
  - the BHT counter typedef bht_ctr_t (logic [1:0]) with its reset constant BHT_RESET = 2'b01.
- One sub-module, bht_sat_table: a parametrised counter array with a combinational read port, an update port and async reset.
- The compare and register logic stays in the top module.

Test Plan:
- Reset: drop rst_n mid-run, then release. Required: all outputs 0 and fetch_pred_o=0 for every index.
- BLT: src_a=0xFFFFFFFF, src_b=1, pred=0. Next cycle: res_valid=1, taken=1, mispredict=1.
- BLTU with the same operands, pred=0. Required: taken=0, mispredict=0.
- Saturation: 4 taken BEQ at pc=0x100 (a=b=5). The counter at idx 0 goes 01→10→11→11, and fetch_pred_o for fetch_pc 0x100 becomes 1 after the first update.
- Stall/flush: hold stall_i=1 with a valid JAL present. Required: outputs unchanged. Then apply flush_i=1 with stall_i=0. Required: res_valid=0 and the BHT unchanged.
- Same-index read/write: fetch_pc=pc=0x104 during a taken update from 01. fetch_pred_o=0 that cycle and 1 the next.
- BRU_PERF_CNT_EN: 10 branches with 3 mispredicts. Required: counts 10/3. Preload both counters to 0xFFFFFFFF, then one mispredicting branch; both wrap to 0.
